// File: rtl/next186_sim_pkg.sv
// Shared definitions for the simulation-side ioctl download path:
// the sender state encoding, default timing, and a timer-load helper.
package next186_sim_pkg;

    localparam int LEAD_DEF = 4;
    localparam int GAP_DEF  = 3;
    localparam int TAIL_DEF = 4;

    localparam int CNT_W  = 8;
    localparam int ADDR_W = 25;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_GAP   = 3'd4,
        ST_TAIL  = 3'd5
    } ioctl_state_e;

    // Load value that keeps a timed state resident for `cycles` clocks (minimum one).
    function automatic logic [CNT_W-1:0] dwell_load(input int cycles);
        logic [CNT_W-1:0] val;
        if (cycles <= 1) begin
            val = {CNT_W{1'b0}};
        end else begin
            val = CNT_W'(cycles - 1);
        end
        return val;
    endfunction

endpackage

// File: rtl/ioctl_cnt.sv
// Loadable down-counter that times the LEAD, GAP and TAIL phases of the sender.
// zero is high once the count has run out; it never underflows.
module ioctl_cnt
    import next186_sim_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a load wins over counting down.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != {CNT_W{1'b0}})) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/ioctl_sender.sv
// Streams a byte source into a core's ioctl download port: a download window
// with LEAD/TAIL padding around one write strobe per byte, spaced by GAP.
module ioctl_sender
    import next186_sim_pkg::*;
#(
    parameter int LEAD = LEAD_DEF,
    parameter int GAP  = GAP_DEF,
    parameter int TAIL = TAIL_DEF
) (
    input  logic                clk_28_636,
    input  logic                reset_n,
    input  logic                start,
    input  logic [7:0]          index,
    input  logic [ADDR_W-1:0]   length,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    output logic                busy,
    output logic                done,
    output logic                ioctl_download,
    output logic                ioctl_wr,
    output logic [ADDR_W-1:0]   ioctl_addr,
    output logic [DATA_W-1:0]   ioctl_dout,
    output logic [7:0]          ioctl_index,
    input  logic                ioctl_wait
);

    // The FETCH handshake cycle counts as one of the idle cycles after a
    // strobe, so the GAP state itself only needs GAP-1 cycles.
    localparam logic [CNT_W-1:0] LEAD_LD = dwell_load(LEAD);
    localparam logic [CNT_W-1:0] GAP_LD  = dwell_load(GAP - 1);
    localparam logic [CNT_W-1:0] TAIL_LD = dwell_load(TAIL);

    ioctl_state_e        state_q,     state_d;
    logic [7:0]          index_q,     index_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   dout_q,      dout_d;
    logic                wr_q,        wr_d;
    logic                download_q,  download_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    logic                handshake_s;
    logic                cnt_load_s;
    logic [CNT_W-1:0]    cnt_val_s;
    logic                cnt_en_s;
    logic                cnt_zero_s;

    // Source handshake is only offered in FETCH and only when the core is not stalling.
    always_comb begin
        handshake_s = 1'b0;
        if (state_q == ST_FETCH) begin
            handshake_s = s_valid && !ioctl_wait;
        end else begin
            handshake_s = 1'b0;
        end
    end

    // Timer runs only in the timed phases.
    always_comb begin
        cnt_en_s = 1'b0;
        case (state_q)
            ST_LEAD, ST_GAP, ST_TAIL: cnt_en_s = 1'b1;
            default:                  cnt_en_s = 1'b0;
        endcase
    end

    ioctl_cnt u_cnt (
        .clk      (clk_28_636),
        .reset_n  (reset_n),
        .load     (cnt_load_s),
        .en       (cnt_en_s),
        .load_val (cnt_val_s),
        .zero     (cnt_zero_s)
    );

    // Next-state and next-output logic of the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        wr_d        = 1'b0;
        download_d  = download_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_val_s   = {CNT_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    index_d     = index;
                    remaining_d = length;
                    addr_d      = {ADDR_W{1'b0}};
                    download_d  = 1'b1;
                    busy_d      = 1'b1;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = LEAD_LD;
                    state_d     = ST_LEAD;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (cnt_zero_s) begin
                    if (remaining_q != {ADDR_W{1'b0}}) begin
                        state_d    = ST_FETCH;
                    end else begin
                        cnt_load_s = 1'b1;
                        cnt_val_s  = TAIL_LD;
                        state_d    = ST_TAIL;
                    end
                end else begin
                    state_d = ST_LEAD;
                end
            end
            ST_FETCH: begin
                if (handshake_s) begin
                    dout_d  = s_data;
                    wr_d    = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WRITE: begin
                remaining_d = remaining_q - ADDR_W'(1);
                cnt_load_s  = 1'b1;
                cnt_val_s   = GAP_LD;
                state_d     = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_zero_s) begin
                    // The address only advances when another byte follows, so it
                    // keeps the last written address once the transfer ends.
                    if (remaining_q != {ADDR_W{1'b0}}) begin
                        addr_d     = addr_q + ADDR_W'(1);
                        state_d    = ST_FETCH;
                    end else begin
                        cnt_load_s = 1'b1;
                        cnt_val_s  = TAIL_LD;
                        state_d    = ST_TAIL;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_TAIL: begin
                if (cnt_zero_s) begin
                    download_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_TAIL;
                end
            end
            default: begin
                download_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Sequencer and output registers with synchronous active-low reset.
    always_ff @(posedge clk_28_636) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            index_q     <= 8'd0;
            remaining_q <= {ADDR_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            dout_q      <= {DATA_W{1'b0}};
            wr_q        <= 1'b0;
            download_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            wr_q        <= wr_d;
            download_q  <= download_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign s_ready        = handshake_s;
    assign busy           = busy_q;
    assign done           = done_q;
    assign ioctl_download = download_q;
    assign ioctl_wr       = wr_q;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
    assign ioctl_index    = index_q;

endmodule

// File: tb/tb_ioctl_sender.sv
// Randomized bench for ioctl_sender: a schedule model derives every expected
// handshake, strobe and window edge from the timing rules, checked per cycle.
module tb_ioctl_sender;

    localparam int LEAD = 4;
    localparam int GAP  = 3;
    localparam int TAIL = 4;
    localparam int MAXC = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  index;
    logic [24:0] length;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;

    bit          valid_a [MAXC];
    bit          wait_a  [MAXC];
    logic [7:0]  bytes_a [16];
    int          hs_a    [16];
    int          el_a    [16];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ioctl_sender dut (
        .clk_28_636     (clk),
        .reset_n        (reset_n),
        .start          (start),
        .index          (index),
        .length         (length),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .busy           (busy),
        .done           (done),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".download"}, 32'(ioctl_download), 32'd0);
        chk({tag, ".wr"},       32'(ioctl_wr),       32'd0);
        chk({tag, ".addr"},     32'(ioctl_addr),     32'd0);
        chk({tag, ".dout"},     32'(ioctl_dout),     32'd0);
        chk({tag, ".index"},    32'(ioctl_index),    32'd0);
        chk({tag, ".s_ready"},  32'(s_ready),        32'd0);
        chk({tag, ".busy"},     32'(busy),           32'd0);
        chk({tag, ".done"},     32'(done),           32'd0);
    endtask

    task automatic reset_dut();
        reset_n = 1'b0; start = 1'b0; s_valid = 1'b1; ioctl_wait = 1'b0;
        index = 8'hFF; length = 25'd5; s_data = 8'hEE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // mode 0: random source/wait/extra starts; 1: clean; 2: wait burst after
    // first write; 3: source stall before second byte. abort_at >= 0 pulls
    // reset in that cycle.
    task automatic run_xfer(input int len, input logic [7:0] idx, input int mode,
                            input int abort_at);
        int t0, elig, cy, tail_start, done_c, last, k, ea, wi;
        bit ew, er;
        string tg;

        for (int i = 0; i < 16; i++) bytes_a[i] = 8'($urandom);
        if (mode != 0) begin
            bytes_a[0] = 8'hA5; bytes_a[1] = 8'h5A; bytes_a[2] = 8'hFF;
        end
        for (int c = 0; c < MAXC; c++) begin
            if (mode == 0 && c < 150) begin
                valid_a[c] = ($urandom_range(0, 9) < 7);
                wait_a[c]  = ($urandom_range(0, 9) < 2);
            end else begin
                valid_a[c] = 1'b1;
                wait_a[c]  = 1'b0;
            end
            if (mode == 2 && c >= 7 && c <= 16) wait_a[c]  = 1'b1;
            if (mode == 3 && c >= 9 && c <= 15) valid_a[c] = 1'b0;
        end

        // Schedule: start in cycle 0, window opens in cycle 1.
        t0   = 1;
        elig = t0 + LEAD;
        for (int i = 0; i < len; i++) begin
            cy = elig;
            while (cy < MAXC - 1 && !(valid_a[cy] && !wait_a[cy])) cy++;
            el_a[i] = elig;
            hs_a[i] = cy;
            elig    = cy + 1 + GAP;
        end
        tail_start = (len == 0) ? (t0 + LEAD) : (hs_a[len-1] + 1 + GAP);
        done_c     = tail_start + TAIL;
        last       = (abort_at >= 0) ? (abort_at + 7) : (done_c + 1);

        k = 0;
        for (int c = 0; c <= last; c++) begin
            start      = (c == 0) || (mode == 0 && c > 0 && c < done_c
                                      && $urandom_range(0, 9) == 0);
            index      = (c == 0) ? idx : 8'($urandom);
            length     = (c == 0) ? 25'(len) : 25'($urandom);
            reset_n    = (c != abort_at);
            s_valid    = valid_a[c];
            ioctl_wait = wait_a[c];
            s_data     = (k < 16) ? bytes_a[k] : 8'h00;

            ew = 1'b0; er = 1'b0; wi = 0; ea = 0;
            for (int i = 0; i < len; i++) begin
                if (hs_a[i] == c)     er = 1'b1;
                if (hs_a[i] + 1 == c) begin ew = 1'b1; wi = i; end
                if (i >= 1 && el_a[i] <= c) ea++;
            end

            @(negedge clk);
            tg = $sformatf("m%0d.len%0d.c%0d", mode, len, c);
            if (abort_at >= 0 && c > abort_at) begin
                chk_all_zero({tg, ".abort"});
            end else begin
                chk({tg, ".download"}, 32'(ioctl_download), 32'(c >= t0 && c < done_c));
                chk({tg, ".busy"},     32'(busy),           32'(c >= t0 && c < done_c));
                chk({tg, ".done"},     32'(done),           32'(c == done_c));
                chk({tg, ".wr"},       32'(ioctl_wr),       32'(ew));
                chk({tg, ".s_ready"},  32'(s_ready),        32'(er));
                if (c >= t0) begin
                    chk({tg, ".index"}, 32'(ioctl_index), 32'(idx));
                    chk({tg, ".addr"},  32'(ioctl_addr),  32'(ea));
                end
                if (ew) chk({tg, ".dout"}, 32'(ioctl_dout), 32'(bytes_a[wi]));
            end
            if (er) k++;
            @(posedge clk); #1;
        end
        start   = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_dut();
        run_xfer(3, 8'h11, 1, -1);
        run_xfer(3, 8'h22, 2, -1);
        run_xfer(3, 8'h33, 3, -1);
        run_xfer(0, 8'h44, 1, -1);
        // Reset lands in the GAP after the second strobe (cycle 10).
        run_xfer(3, 8'h55, 1, 11);
        run_xfer(3, 8'h66, 1, -1);
        for (int n = 0; n < 20; n++) begin
            run_xfer(int'($urandom_range(0, 8)), 8'($urandom), 0, -1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ioctl_sender.md
IOCTL_SENDER -- requirements
Module: ioctl_sender

Interface
REQ-001 SHALL have parameter LEAD, default 4: cycles ioctl_download is high before the first write.
REQ-002 SHALL have parameter GAP, default 3: minimum idle cycles after each ioctl_wr pulse.
REQ-003 SHALL have parameter TAIL, default 4: cycles ioctl_download stays high after the last write.
REQ-004 SHALL have port clk_28_636  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a transfer.
REQ-007 SHALL have port index  in  8  file index, latched on an accepted start.
REQ-008 SHALL have port length  in  25  byte count, latched on an accepted start.
REQ-009 SHALL have port s_valid  in  1  source byte available.
REQ-010 SHALL have port s_data  in  8  source byte.
REQ-011 SHALL have port s_ready  out  1  byte consumed this cycle.
REQ-012 SHALL have port busy  out  1  transfer in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse at the end of a transfer.
REQ-014 SHALL have port ioctl_download  out  1  transfer window.
REQ-015 SHALL have port ioctl_wr  out  1  one-cycle write strobe.
REQ-016 SHALL have port ioctl_addr  out  25  byte address.
REQ-017 SHALL have port ioctl_dout  out  8  byte data.
REQ-018 SHALL have port ioctl_index  out  8  latched index.
REQ-019 SHALL have port ioctl_wait  in  1  core back-pressure; while high, no new write is issued.

Function
REQ-020 SHALL implement states IDLE, LEAD, FETCH, WRITE, GAP, TAIL.
REQ-021 IDLE: start=1 SHALL latch index/length, set the address counter to 0 and remaining=length, then go to LEAD; busy rises the next cycle.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 LEAD: ioctl_download=1 for exactly LEAD cycles, then FETCH if remaining>0, else TAIL.
REQ-024 FETCH: s_ready=1 only when s_valid=1 and ioctl_wait=0; on that handshake it SHALL load ioctl_dout<=s_data and go to WRITE.
REQ-025 s_ready SHALL be 0 in every state other than FETCH.
REQ-026 WRITE: ioctl_wr=1 for exactly one cycle; ioctl_addr and ioctl_dout SHALL be valid in that cycle; remaining is decremented; state goes to GAP.
REQ-027 GAP: ioctl_wr=0; ioctl_addr/ioctl_dout held; after GAP cycles, the address increments by 1 and state goes to FETCH if remaining>0, else TAIL.
REQ-028 ioctl_wait rising during WRITE or GAP SHALL NOT truncate the strobe; it only blocks the next FETCH handshake.
REQ-029 A source stall (s_valid=0) SHALL hold FETCH indefinitely with all outputs stable.
REQ-030 TAIL: ioctl_download=1 for TAIL cycles, then ioctl_download=0, done=1 for one cycle, busy=0, and state returns to IDLE.
REQ-031 ioctl_addr SHALL wrap modulo 2^25; a length of 0 produces a download window with zero writes.
REQ-032 Outside an active transfer, ioctl_index SHALL hold the last latched value and ioctl_addr SHALL hold the last written address.

Reset
REQ-033 reset_n=0 at a clock edge SHALL force IDLE and set all outputs to 0: ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, s_ready, busy, done.
REQ-034 Reset mid-transfer SHALL drop ioctl_download in the next cycle with no done pulse; any partially sent data is abandoned.

Structure
REQ-035 SHALL place the state encoding and the LEAD/GAP/TAIL defaults in shared package next186_sim_pkg.
REQ-036 SHALL use one sub-module, ioctl_cnt: a loadable down-counter used for the LEAD, GAP and TAIL timing.
REQ-037 The block SHALL be instantiated by the Verilator top to drive the core's ioctl_* inputs.

Verification
REQ-038 length=3, source bytes A5,5A,FF always valid, wait=0 -> download high; wr pulses at addr 0,1,2 with matching data, spaced 4 cycles apart; one done pulse.
REQ-039 ioctl_wait held high for 10 cycles after the first write -> the second wr occurs no earlier than 1 cycle after wait falls; addr=1, data correct.
REQ-040 s_valid low for 7 cycles before the second byte -> no wr during the stall; s_ready pulses exactly 3 times in total.
REQ-041 length=0 -> download high for LEAD+TAIL=8 cycles, no wr, then done.
REQ-042 start pulsed again mid-transfer -> ignored; latched index unchanged.
REQ-043 reset_n low during GAP of byte 2 -> download=0 and all outputs 0 next cycle; no done; a fresh start afterwards begins again at addr 0.
